// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   OP_*        : encoding of the 2-bit op port
//   mdu_state_t : sequencer states (IDLE, BUSY, FINISH)
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH
    } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation.
// Ports:
//   value  : input word
//   negate : when high, result = -value, otherwise result = value
//   result : output word
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one bit per cycle; signs are fixed up on the final edge.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start, op         : launch request (sampled in IDLE) and operation
//   SrcA, SrcB        : operands (multiplicand/dividend, multiplier/divisor)
//   hi_we, lo_we      : MTHI/MTLO writes of SrcA, honoured only in IDLE
//   busy, done        : sequencer active, one-cycle completion pulse
//   div_by_zero       : pulses with done for a divide by zero
//   HI, LO            : architectural result registers
// Build option: define MDU_DIV_EN to include DIV/DIVU; otherwise divide
// starts are ignored and no divider is built.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  hi_we,
    input  logic                  lo_we,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    mdu_state_t            state;
    logic [CNT_W-1:0]      cnt;
    // acc: upper product half / partial remainder
    // quo: multiplier shifting out, low product half / dividend shifting out, quotient
    // dsr: multiplicand or divisor magnitude
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] dsr;
    logic                  neg_res;

    logic                    signed_op;
    logic                    a_neg;
    logic                    b_neg;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   a_mag;
    logic [DATA_WIDTH-1:0]   b_mag;
    logic [2*DATA_WIDTH-1:0] res_raw;
    logic [2*DATA_WIDTH-1:0] res_fix;
    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH-1:0]   acc_step;
    logic [DATA_WIDTH-1:0]   quo_step;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & SrcA[DATA_WIDTH-1];
    assign b_neg     = signed_op & SrcB[DATA_WIDTH-1];

    mdu_sign_fix #(.WIDTH(DATA_WIDTH)) u_a_fix (
        .value  (SrcA),
        .negate (a_neg),
        .result (a_mag)
    );

    mdu_sign_fix #(.WIDTH(DATA_WIDTH)) u_b_fix (
        .value  (SrcB),
        .negate (b_neg),
        .result (b_mag)
    );

    // Quotient is negated through the wide fixer; its low half equals -quotient.
    mdu_sign_fix #(.WIDTH(2*DATA_WIDTH)) u_res_fix (
        .value  (res_raw),
        .negate (neg_res),
        .result (res_fix)
    );

    assign mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, dsr} : '0);

`ifdef MDU_DIV_EN
    logic                  is_div;
    logic                  dbz;
    logic                  neg_rem;
    logic [DATA_WIDTH:0]   div_shift;
    logic                  div_ge;
    logic [DATA_WIDTH-1:0] div_diff;
    logic [DATA_WIDTH-1:0] rem_fix;

    assign accept    = start;
    assign div_shift = {acc, quo[DATA_WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, dsr};
    // Partial remainder stays below the divisor, so the difference fits in DATA_WIDTH bits.
    assign div_diff  = DATA_WIDTH'(div_shift - {1'b0, dsr});
    assign res_raw   = is_div ? {{DATA_WIDTH{1'b0}}, quo} : {acc, quo};

    mdu_sign_fix #(.WIDTH(DATA_WIDTH)) u_rem_fix (
        .value  (acc),
        .negate (neg_rem),
        .result (rem_fix)
    );
`else
    assign accept      = start & ~op[1];
    assign res_raw     = {acc, quo};
    assign div_by_zero = 1'b0;
`endif

    always_comb begin
        acc_step = mul_sum[DATA_WIDTH:1];
        quo_step = {mul_sum[0], quo[DATA_WIDTH-1:1]};
`ifdef MDU_DIV_EN
        if (is_div) begin
            acc_step = div_ge ? div_diff : div_shift[DATA_WIDTH-1:0];
            quo_step = {quo[DATA_WIDTH-2:0], div_ge};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            HI      <= '0;
            LO      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            acc     <= '0;
            quo     <= '0;
            dsr     <= '0;
            neg_res <= 1'b0;
`ifdef MDU_DIV_EN
            div_by_zero <= 1'b0;
            is_div      <= 1'b0;
            dbz         <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MDU_DIV_EN
            div_by_zero <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy    <= 1'b1;
                        cnt     <= '0;
                        acc     <= '0;
                        neg_res <= a_neg ^ b_neg;
                        quo     <= b_mag;
                        dsr     <= a_mag;
                        state   <= BUSY;
`ifdef MDU_DIV_EN
                        is_div  <= op[1];
                        neg_rem <= a_neg;
                        dbz     <= op[1] & (SrcB == '0);
                        if (op[1]) begin
                            quo <= a_mag;
                            dsr <= b_mag;
                            // Divide by zero: no iterations; HI reports the raw dividend.
                            if (SrcB == '0) begin
                                acc   <= SrcA;
                                state <= FINISH;
                            end
                        end
`endif
                    end else if (!start) begin
                        // Any start in the same cycle, accepted or not, drops MTHI/MTLO.
                        if (hi_we) HI <= SrcA;
                        if (lo_we) LO <= SrcA;
                    end
                end
                BUSY: begin
                    acc <= acc_step;
                    quo <= quo_step;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
`ifdef MDU_DIV_EN
                    if (dbz) begin
                        HI          <= acc;
                        LO          <= '1;
                        div_by_zero <= 1'b1;
                    end else if (is_div) begin
                        HI <= rem_fix;
                        LO <= res_fix[DATA_WIDTH-1:0];
                    end else begin
                        {HI, LO} <= res_fix;
                    end
`else
                    {HI, LO} <= res_fix;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
